adat_frame_transmitter: RTL and testbench

Reads completed 256-bit frames out of the `channel_buffer` RAM that `i2s_msb_receiver` fills. Reformats each frame (8 channels × 32-bit MSB-first slots, top 24 bits used) into a 256-bit ADAT frame and emits it NRZI-encoded, one bit per `bit_strobe_i`. It is the consumer stage between the channel buffer's read port and the optical output pin.

---
 rtl/adat_pkg.sv | 38 +++
 rtl/adat_nrzi_encoder.sv | 33 +++
 rtl/adat_frame_transmitter.sv | 161 ++++++++++++++++
 tb/tb_adat_frame_transmitter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adat_pkg.sv
// ---------------------------------------------------------------------------
// adat_pkg
// Shared ADAT framing constants, the transmitter state type and a helper
// that maps a frame position to the section it belongs to.
// ---------------------------------------------------------------------------
package adat_pkg;

  localparam int ADAT_FRAME_BITS = 256;
  localparam int ADAT_SYNC_ZEROS = 10;
  localparam int ADAT_CHANNELS   = 8;
  localparam int SLOT_BITS       = 32;
  localparam int SAMPLE_BITS     = 24;
  localparam int NIBBLE_BITS     = 5;

  // Sized position landmarks so comparisons against 8-bit counters stay width-exact.
  localparam logic [7:0] POS_SYNC_ONE   = 8'(ADAT_SYNC_ZEROS);
  localparam logic [7:0] POS_USER_FIRST = 8'(ADAT_SYNC_ZEROS + 1);
  localparam logic [7:0] POS_USER_SEP   = 8'(ADAT_SYNC_ZEROS + 5);
  localparam logic [7:0] POS_DATA_FIRST = 8'(ADAT_SYNC_ZEROS + 6);
  localparam logic [7:0] POS_LAST       = 8'(ADAT_FRAME_BITS - 1);
  localparam logic [4:0] SLOT_LAST_BIT  = 5'(SAMPLE_BITS - 1);
  localparam logic [2:0] NIBBLE_LAST    = 3'(NIBBLE_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    USER,
    DATA
  } adat_tx_state_t;

  // Section that frame position 'pos' falls in (never IDLE).
  function automatic adat_tx_state_t section_of(input logic [7:0] pos);
    if (pos < POS_USER_FIRST) return SYNC;
    if (pos < POS_DATA_FIRST) return USER;
    return DATA;
  endfunction

endpackage

// File: rtl/adat_nrzi_encoder.sv
// ---------------------------------------------------------------------------
// adat_nrzi_encoder
// Strobe-gated NRZI encoder: the line toggles for a logical 1 and holds for a
// logical 0, updating only on cycles where bit_en_i is high.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (line resets to 0)
//   bit_en_i       : one-cycle enable, one per bit period
//   bit_i          : logical bit to encode
//   line_o         : NRZI line level
// ---------------------------------------------------------------------------
module adat_nrzi_encoder (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic bit_en_i,
  input  logic bit_i,
  output logic line_o
);

  logic line_q, line_d;

  always_comb begin
    line_d = (bit_en_i && bit_i) ? ~line_q : line_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) line_q <= 1'b0;
    else          line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/adat_frame_transmitter.sv
// ---------------------------------------------------------------------------
// adat_frame_transmitter
// Reads 256-bit frames from the channel buffer and emits them as NRZI ADAT
// frames, one bit per bit_strobe_i.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   enable_i                : transmit request, sampled at frame boundaries
//   bit_strobe_i            : one pulse per ADAT bit period (>= 3 clocks apart)
//   last_good_frame_idx_i   : newest complete frame in the channel buffer
//   user_bits_i             : U3..U0, latched at frame start
//   ram_read_addr_o         : {frame_idx, channel[2:0], sample_bit[4:0]}
//   ram_read_data_i         : read data, valid one clock after the address
//   adat_o                  : NRZI line
//   frame_start_o           : pulse while adat_o carries frame position 0
//   underrun_o              : pulse (with frame_start_o) when a frame is muted
// ---------------------------------------------------------------------------
module adat_frame_transmitter
  import adat_pkg::*;
#(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       enable_i,
  input  logic                       bit_strobe_i,
  input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
  input  logic [3:0]                 user_bits_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  input  logic                       ram_read_data_i,
  output logic                       adat_o,
  output logic                       frame_start_o,
  output logic                       underrun_o
);

  adat_tx_state_t             state_q, state_d;
  logic [7:0]                 pos_q, pos_d;          // position emitted on the next strobe
  logic [2:0]                 sub_q, sub_d;          // index within a 5-bit nibble, 0 = separator
  logic [CIRC_BUF_BITS-1:0]   frame_idx_q, frame_idx_d;
  logic [3:0]                 user_q, user_d;
  logic                       first_q, first_d;
  logic                       mute_q, mute_d;
  logic [CIRC_BUF_BITS+7:0]   addr_q, addr_d;
  logic                       fetch1_q, fetch1_d;    // RAM presenting data for the new address
  logic                       fetch2_q, fetch2_d;    // RAM data valid: capture now
  logic                       sample_q, sample_d;
  logic                       frame_start_q, frame_start_d;
  logic                       underrun_q, underrun_d;

  logic       emit;
  logic       tx_bit;
  logic       stale;
  logic [3:0] user_sel;

  // A strobe emits a bit whenever a frame is in flight, or starts one from IDLE.
  assign emit = bit_strobe_i && ((state_q != IDLE) || enable_i);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    pos_d         = pos_q;
    sub_d         = sub_q;
    frame_idx_d   = frame_idx_q;
    user_d        = user_q;
    first_d       = first_q;
    mute_d        = mute_q;
    addr_d        = addr_q;
    fetch1_d      = 1'b0;
    fetch2_d      = fetch1_q;
    sample_d      = fetch2_q ? ram_read_data_i : sample_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    user_sel = 4'd14 - pos_q[3:0];   // position 11 -> U3 ... 14 -> U0
    stale    = !first_q && (last_good_frame_idx_i == frame_idx_q);

    case (state_q)
      SYNC:    tx_bit = (pos_q == POS_SYNC_ONE);
      USER:    tx_bit = (pos_q == POS_USER_SEP) ? 1'b1 : user_q[user_sel[1:0]];
      DATA:    tx_bit = (sub_q == 3'd0) ? 1'b1 : (sample_q & ~mute_q);
      default: tx_bit = 1'b0;        // IDLE only emits when starting position 0
    endcase

    if (emit) begin
      fetch1_d = 1'b1;

      if (pos_q == 8'd0) begin
        // Frame latch; the sample pointer restarts at channel 0, bit 0.
        frame_idx_d   = last_good_frame_idx_i;
        user_d        = user_bits_i;
        mute_d        = stale;
        underrun_d    = stale;
        first_d       = 1'b0;
        frame_start_d = 1'b1;
        addr_d        = {last_good_frame_idx_i, 8'd0};
      end else if ((state_q == DATA) && (sub_q != 3'd0)) begin
        // Sample bit consumed: prefetch the next one, skipping slot bits 24..31.
        if (addr_q[4:0] == SLOT_LAST_BIT) begin
          addr_d[7:5] = addr_q[7:5] + 3'd1;
          addr_d[4:0] = 5'd0;
        end else begin
          addr_d[4:0] = addr_q[4:0] + 5'd1;
        end
      end

      sub_d = ((state_q == DATA) && (sub_q != NIBBLE_LAST)) ? sub_q + 3'd1 : 3'd0;

      if (pos_q == POS_LAST) begin
        pos_d   = 8'd0;
        state_d = enable_i ? SYNC : IDLE;
      end else begin
        pos_d   = pos_q + 8'd1;
        state_d = section_of(pos_d);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      pos_q         <= 8'd0;
      sub_q         <= 3'd0;
      frame_idx_q   <= '0;
      user_q        <= 4'd0;
      first_q       <= 1'b1;
      mute_q        <= 1'b0;
      addr_q        <= '0;
      fetch1_q      <= 1'b0;
      fetch2_q      <= 1'b0;
      sample_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      sub_q         <= sub_d;
      frame_idx_q   <= frame_idx_d;
      user_q        <= user_d;
      first_q       <= first_d;
      mute_q        <= mute_d;
      addr_q        <= addr_d;
      fetch1_q      <= fetch1_d;
      fetch2_q      <= fetch2_d;
      sample_q      <= sample_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  adat_nrzi_encoder u_nrzi (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bit_en_i(emit),
    .bit_i   (tx_bit),
    .line_o  (adat_o)
  );

  assign ram_read_addr_o = addr_q;
  assign frame_start_o   = frame_start_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_adat_frame_transmitter.sv
// ---------------------------------------------------------------------------
// tb_adat_frame_transmitter
// Scoreboard bench: each strobe pushes the expected line level and pulses;
// a monitor pops and compares one clock later. Hand-computed patterns are
// checked on the decoded bits captured per frame position.
// ---------------------------------------------------------------------------
module tb_adat_frame_transmitter;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        bit_strobe_i = 1'b0;
  logic [2:0]  last_good_frame_idx_i = 3'd0;
  logic [3:0]  user_bits_i = 4'd0;
  logic [10:0] ram_read_addr_o;
  logic        ram_read_data_i;
  logic        adat_o, frame_start_o, underrun_o;

  adat_frame_transmitter #(.CIRC_BUF_BITS(3)) dut (
    .clk_i                (clk_i),
    .rst_n_i              (rst_n_i),
    .enable_i             (enable_i),
    .bit_strobe_i         (bit_strobe_i),
    .last_good_frame_idx_i(last_good_frame_idx_i),
    .user_bits_i          (user_bits_i),
    .ram_read_addr_o      (ram_read_addr_o),
    .ram_read_data_i      (ram_read_data_i),
    .adat_o               (adat_o),
    .frame_start_o        (frame_start_o),
    .underrun_o           (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Channel buffer model: synchronous read, data one clock after the address.
  logic mem [0:2047];
  always @(posedge clk_i) ram_read_data_i <= mem[ram_read_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic level;
    logic fs;
    logic ur;
    int   pos;
  } exp_t;

  exp_t sb[$];

  bit         m_active = 1'b0;
  bit         m_first  = 1'b1;
  int         m_pos    = 0;
  logic [2:0] m_idx    = 3'd0;
  logic [3:0] m_user   = 4'd0;
  logic       m_mute   = 1'b0;
  logic       m_level  = 1'b0;

  function automatic logic model_bit(input int p);
    int d, c, r, k;
    if (p < 10)  return 1'b0;
    if (p == 10) return 1'b1;
    if (p < 15)  return m_user[14-p];
    if (p == 15) return 1'b1;
    d = p - 16;
    c = d / 30;
    r = d % 30;
    if (r % 5 == 0) return 1'b1;
    k = (r / 5) * 4 + (r % 5) - 1;
    if (m_mute) return 1'b0;
    return mem[{m_idx, 3'(c), 5'(k)}];
  endfunction

  task automatic do_strobe();
    exp_t e;
    e.fs  = 1'b0;
    e.ur  = 1'b0;
    e.pos = -1;
    if (m_active || enable_i) begin
      if (m_pos == 0) begin
        e.fs    = 1'b1;
        e.ur    = !m_first && (last_good_frame_idx_i == m_idx);
        m_mute  = e.ur;
        m_idx   = last_good_frame_idx_i;
        m_user  = user_bits_i;
        m_first = 1'b0;
      end
      e.pos = m_pos;
      if (model_bit(m_pos)) m_level = ~m_level;
      if (m_pos == 255) begin
        m_pos    = 0;
        m_active = enable_i;
      end else begin
        m_pos++;
        m_active = 1'b1;
      end
    end
    e.level = m_level;
    sb.push_back(e);
    @(negedge clk_i) bit_strobe_i = 1'b1;
    @(negedge clk_i) bit_strobe_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  // Strobe at least once, then until the model reaches 'target'.
  task automatic run_until(input int target, input string name);
    int n = 0;
    do begin
      do_strobe();
      n++;
    end while (m_pos != target && n < 300);
    if (m_pos != target) check({name, "_bound"}, 32'(m_pos), 32'(target));
  endtask

  // ---------------- monitor ----------------
  logic mon_prev = 1'b0;
  int   ur_seen  = 0;
  logic cap [0:255];

  always @(posedge clk_i) begin
    exp_t e;
    if (bit_strobe_i && rst_n_i) begin
      #1;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("adat_level", 32'(adat_o), 32'(e.level));
        check("fs_ur", 32'({frame_start_o, underrun_o}), 32'({e.fs, e.ur}));
        if (e.pos >= 0) cap[e.pos] = adat_o ^ mon_prev;
        if (underrun_o) ur_seen++;
        mon_prev = adat_o;
      end
    end
  end

  // Address / idle watchers.
  int         off_bad = 0, rng_bad = 0, idle_addr = 0, idle_fs = 0, idle_tog = 0;
  logic       rng_en = 1'b0, idle_en = 1'b0;
  logic [2:0] rng_frame = 3'd2;

  always @(posedge clk_i) begin
    #1;
    if (rst_n_i && ram_read_addr_o[4:0] >= 5'd24) off_bad++;
    if (rng_en && ram_read_addr_o[10:8] != rng_frame) rng_bad++;
    if (idle_en && ram_read_addr_o != 11'd0) idle_addr++;
    if (idle_en && frame_start_o) idle_fs++;
  end

  always @(adat_o) if (idle_en) idle_tog++;

  function automatic int ones(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(cap[i]);
    return n;
  endfunction

  task automatic clear_cap();
    for (int i = 0; i < 256; i++) cap[i] = 1'b0;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] ch0_val;
    logic [15:0] head;
    logic [29:0] ch0_bits;
    logic [10:0] a;

    ch0_val = 24'hABCDEF;
    for (int i = 0; i < 2048; i++) begin
      a = 11'(i);
      mem[i] = 1'b0;
      if (a[10:8] == 3'd3) mem[i] = 1'b1;                      // frame 3: all ones
      if (a[10:8] == 3'd4) mem[i] = a[0] ^ a[2] ^ a[5];        // frame 4: mixed pattern
    end
    for (int k = 0; k < 24; k++) begin
      mem[{3'd2, 3'd0, 5'(k)}] = ch0_val[23-k];
      mem[{3'd2, 3'd7, 5'(k)}] = 1'b1;
    end
    clear_cap();

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_adat", 32'(adat_o), 32'd0);
    check("rst_fs", 32'(frame_start_o), 32'd0);
    check("rst_ur", 32'(underrun_o), 32'd0);
    check("rst_addr", 32'(ram_read_addr_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Frame A: sync/user pattern, channel 0 mapping, channel 7 boundary.
    enable_i = 1'b1;
    last_good_frame_idx_i = 3'd2;
    user_bits_i = 4'b0101;
    do_strobe();
    rng_en = 1'b1;
    run_until(0, "frame_a");
    rng_en = 1'b0;
    for (int i = 0; i < 16; i++) head[15-i] = cap[i];
    for (int i = 0; i < 30; i++) ch0_bits[29-i] = cap[16+i];
    check("sync_user_bits", 32'(head), 32'(16'b0000000000_1_0101_1));
    check("ch0_abcdef", 32'(ch0_bits), 32'(30'b1_1010_1_1011_1_1100_1_1101_1_1110_1_1111));
    check("ch7_all_ones", 32'(ones(226, 255)), 32'd30);
    check("addr_in_frame2", 32'(rng_bad), 32'd0);

    // Frame B: same index again -> muted, one underrun pulse.
    ur_seen = 0;
    run_until(0, "frame_b");
    check("underrun_once", 32'(ur_seen), 32'd1);
    check("muted_only_seps", 32'(ones(16, 255)), 32'd48);

    // Frame C: new index -> not muted.
    last_good_frame_idx_i = 3'd3;
    ur_seen = 0;
    run_until(0, "frame_c");
    check("no_underrun_new_idx", 32'(ur_seen), 32'd0);
    check("frame3_all_ones", 32'(ones(16, 255)), 32'd240);

    // Frame D: enable drops at position 100, frame still completes.
    last_good_frame_idx_i = 3'd4;
    clear_cap();
    run_until(101, "frame_d_head");
    enable_i = 1'b0;
    run_until(0, "frame_d_tail");
    check("disable_completes", 32'(cap[251]), 32'd1);
    idle_en = 1'b1;
    idle_fs = 0;
    idle_tog = 0;
    repeat (20) do_strobe();
    idle_en = 1'b0;
    check("idle_after_disable_fs", 32'(idle_fs), 32'd0);
    check("idle_after_disable_tog", 32'(idle_tog), 32'd0);

    // Frame E: reset at position 100 -> immediate idle.
    enable_i = 1'b1;
    run_until(101, "frame_e_head");
    @(negedge clk_i) rst_n_i = 1'b0;
    #1;
    m_active = 1'b0;
    m_pos    = 0;
    m_first  = 1'b1;
    m_level  = 1'b0;
    mon_prev = 1'b0;
    check("midrst_adat", 32'(adat_o), 32'd0);
    check("midrst_addr", 32'(ram_read_addr_o), 32'd0);
    check("midrst_fs_ur", 32'({frame_start_o, underrun_o}), 32'd0);
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Idle for 1000 strobes after reset.
    idle_en = 1'b1;
    idle_fs = 0;
    idle_tog = 0;
    idle_addr = 0;
    repeat (1000) do_strobe();
    idle_en = 1'b0;
    check("idle_no_fs", 32'(idle_fs), 32'd0);
    check("idle_no_toggle", 32'(idle_tog), 32'd0);
    check("idle_addr_zero", 32'(idle_addr), 32'd0);
    check("idle_adat_low", 32'(adat_o), 32'd0);

    // Frame F: same index as before reset, but first frame -> no underrun.
    enable_i = 1'b1;
    ur_seen = 0;
    run_until(0, "frame_f");
    check("first_after_reset_no_ur", 32'(ur_seen), 32'd0);

    repeat (4) @(negedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("no_offset_24_31", 32'(off_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
